// File: rtl/image_streamer_pkg.sv
// Shared widths, types and FSM encoding for the MNIST frame streamer and its CNN-facing neighbours.
package image_streamer_pkg;

   localparam int unsigned GS_BITS        = 8;
   localparam int unsigned BCD_BITS       = 4;
   localparam int unsigned IMG_PIXELS     = 784;
   localparam int unsigned PIX_ADDR_BITS  = 10;
   localparam int unsigned FRAME_CNT_BITS = 16;

   typedef logic [GS_BITS-1:0]        pixel_t;
   typedef logic [BCD_BITS-1:0]       digit_t;
   typedef logic [PIX_ADDR_BITS-1:0]  pix_addr_t;
   typedef logic [FRAME_CNT_BITS-1:0] frame_cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      GAP,
      WAIT_RESULT
   } state_t;

   // True when a host address falls inside the 28x28 frame.
   function automatic logic addr_in_frame(input pix_addr_t addr);
      return 32'(addr) < IMG_PIXELS;
   endfunction

endpackage

// File: rtl/image_streamer_if.sv
// Host write port, CNN pixel/digit handshake and status outputs of the frame streamer.
interface image_streamer_if;
   import image_streamer_pkg::*;

   logic       host_wr_en;
   pix_addr_t  host_wr_addr;
   pixel_t     host_wr_data;
   logic       host_wr_err;
   logic       start;
   logic       busy;
   pixel_t     pixel_o;
   logic       pixel_o_valid;
   digit_t     digit_i;
   logic       digit_i_valid;
   digit_t     result_o;
   logic       result_valid_o;
   logic       timeout_o;
   frame_cnt_t frame_cnt_o;

   modport slave (
      input  host_wr_en, host_wr_addr, host_wr_data, start, digit_i, digit_i_valid,
      output host_wr_err, busy, pixel_o, pixel_o_valid, result_o, result_valid_o,
             timeout_o, frame_cnt_o
   );

   modport master (
      output host_wr_en, host_wr_addr, host_wr_data, start, digit_i, digit_i_valid,
      input  host_wr_err, busy, pixel_o, pixel_o_valid, result_o, result_valid_o,
             timeout_o, frame_cnt_o
   );

endinterface

// File: rtl/image_frame_ram.sv
// One-frame pixel store: single clock, one write port, one registered read port.
module image_frame_ram
   import image_streamer_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      wr_en,
   input  pix_addr_t wr_addr,
   input  pixel_t    wr_data,
   input  logic      rd_en,
   input  pix_addr_t rd_addr,
   output pixel_t    rd_data
);

   pixel_t mem [IMG_PIXELS];

   // Contents are deliberately not reset so a frame survives a streamer reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Output returns to zero on idle cycles so it doubles as the qualified pixel bus.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
      else            rd_data <= '0;
   end

endmodule

// File: rtl/image_streamer.sv
// Buffers one host-written frame, streams it in raster order to the CNN and returns the digit.
module image_streamer
   import image_streamer_pkg::*;
#(
   parameter int unsigned PIXEL_GAP      = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   image_streamer_if.slave  bus
);

   localparam int unsigned TMO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GAP_BITS = (PIXEL_GAP > 1) ? $clog2(PIXEL_GAP) : 1;
   localparam pix_addr_t   LAST_ADDR = PIX_ADDR_BITS'(IMG_PIXELS - 1);

   state_t              state, state_nxt;
   pix_addr_t           rd_addr, rd_addr_nxt;
   logic [GAP_BITS-1:0] gap_cnt, gap_nxt;
   logic [TMO_BITS-1:0] tmo_cnt, tmo_nxt;
   logic                rd_en_c, accept_c, timeout_c, wr_ok_c;

   logic       busy_q, pix_valid_q, result_valid_q, timeout_q, wr_err_q;
   digit_t     result_q;
   frame_cnt_t frame_cnt_q;
   pixel_t     rd_data;

   assign wr_ok_c = bus.host_wr_en && (state == IDLE) && addr_in_frame(bus.host_wr_addr);

   image_frame_ram u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok_c),
      .wr_addr (bus.host_wr_addr),
      .wr_data (bus.host_wr_data),
      .rd_en   (rd_en_c),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Next-state and per-cycle strobes.
   always_comb begin
      state_nxt   = state;
      rd_addr_nxt = rd_addr;
      gap_nxt     = gap_cnt;
      tmo_nxt     = tmo_cnt;
      rd_en_c     = 1'b0;
      accept_c    = 1'b0;
      timeout_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt   = STREAM;
               rd_addr_nxt = '0;
            end
         end
         STREAM: begin
            rd_en_c = 1'b1;
            if (rd_addr == LAST_ADDR) begin
               state_nxt = WAIT_RESULT;
               tmo_nxt   = '0;
            end else begin
               rd_addr_nxt = rd_addr + PIX_ADDR_BITS'(1);
               if (PIXEL_GAP != 0) begin
                  state_nxt = GAP;
                  gap_nxt   = '0;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_BITS'(PIXEL_GAP - 1)) state_nxt = STREAM;
            else                                     gap_nxt   = gap_cnt + GAP_BITS'(1);
         end
         WAIT_RESULT: begin
            // A digit arriving on the final timeout cycle still counts as a result.
            if (bus.digit_i_valid) begin
               accept_c  = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
               timeout_c = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_nxt = tmo_cnt + TMO_BITS'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rd_addr        <= '0;
         gap_cnt        <= '0;
         tmo_cnt        <= '0;
         busy_q         <= 1'b0;
         pix_valid_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         wr_err_q       <= 1'b0;
         frame_cnt_q    <= '0;
      end else begin
         state          <= state_nxt;
         rd_addr        <= rd_addr_nxt;
         gap_cnt        <= gap_nxt;
         tmo_cnt        <= tmo_nxt;
         busy_q         <= (state_nxt != IDLE);
         pix_valid_q    <= rd_en_c;
         result_valid_q <= accept_c;
         timeout_q      <= timeout_c;
         wr_err_q       <= bus.host_wr_en && !wr_ok_c;
         if (accept_c) begin
            result_q    <= bus.digit_i;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_BITS'(1);
         end
      end
   end

   assign bus.host_wr_err    = wr_err_q;
   assign bus.busy           = busy_q;
   assign bus.pixel_o        = rd_data;
   assign bus.pixel_o_valid  = pix_valid_q;
   assign bus.result_o       = result_q;
   assign bus.result_valid_o = result_valid_q;
   assign bus.timeout_o      = timeout_q;
   assign bus.frame_cnt_o    = frame_cnt_q;

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
Host-side pixel source for the MNIST CNN core. It buffers one 28x28 greyscale frame written by the host and streams it in raster order on the CNN pixel input (pixel/valid). It then waits for the digit classification and returns it to the host with a timeout guard.
It sits between the host/UART loader and the CNN top, driving pixel_i/pixel_i_valid and consuming digit_o/digit_o_valid.

Parameters:
GS_BITS, 8, pixel greyscale width
BCD_BITS, 4, classified digit width
IMG_PIXELS, 784, pixels per frame (28x28)
PIX_ADDR_BITS, 10, frame buffer address width
PIXEL_GAP, 0, idle cycles inserted between consecutive pixels (0 = back-to-back)
TIMEOUT_CYCLES, 1000000, max cycles to wait for a result after the last pixel
FRAME_CNT_BITS, 16, completed-frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
host_wr_en  in  1  frame buffer write strobe
host_wr_addr  in  PIX_ADDR_BITS  write address (row-major, 0..783)
host_wr_data  in  GS_BITS  pixel value
host_wr_err  out  1  1-cycle pulse: write rejected (busy or address >= IMG_PIXELS)
start  in  1  begin streaming stored frame
busy  out  1  high whenever state != IDLE
pixel_o  out  GS_BITS  pixel to CNN
pixel_o_valid  out  1  pixel_o qualifier
digit_i  in  BCD_BITS  CNN classification
digit_i_valid  in  1  classification strobe
result_o  out  BCD_BITS  last accepted digit (held)
result_valid_o  out  1  1-cycle pulse when result_o updates
timeout_o  out  1  1-cycle pulse on result timeout
frame_cnt_o  out  FRAME_CNT_BITS  frames completed with a result

Behaviour:
- Reset: state IDLE; pixel_o=0, pixel_o_valid=0, busy=0, result_o=0, result_valid_o=0, timeout_o=0, host_wr_err=0, frame_cnt_o=0; all counters 0. Frame RAM contents are not reset and are retained.
- Frame RAM: simple dual-port, IMG_PIXELS x GS_BITS, synchronous read with 1-cycle latency.
- Host writes are accepted only in IDLE with addr < IMG_PIXELS. Otherwise the RAM is untouched and host_wr_err pulses the following cycle.
- FSM states: IDLE, STREAM, GAP, WAIT_RESULT.
- IDLE: start=1 -> STREAM; rd_addr=0, pix_cnt=0. start is ignored in all other states.
- STREAM: issue rd_addr each cycle. pixel_o_valid is asserted in the cycle after each issue (RAM latency), with pixel_o = RAM[addr].
  - With PIXEL_GAP=0: exactly IMG_PIXELS consecutive valid cycles.
  - With PIXEL_GAP>0: STREAM -> GAP for PIXEL_GAP cycles after each issue, then back to STREAM.
  - After issuing address IMG_PIXELS-1 -> WAIT_RESULT; the last valid pixel appears in the first WAIT_RESULT cycle.
- Latency: start sampled at edge N gives first pixel_o_valid at edge N+2. Last valid pixel at N+1+IMG_PIXELS*(1+PIXEL_GAP)-PIXEL_GAP.
- pixel_o_valid is never high outside the pixel-delivery cycles. pixel_o is don't-care when valid is low; drive it to 0.
- WAIT_RESULT: the timeout counter starts at 0 when the state is entered.
  - digit_i_valid=1: result_o<=digit_i, result_valid_o pulses next cycle, frame_cnt_o increments (wraps at 2^FRAME_CNT_BITS), -> IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without digit_i_valid: timeout_o pulses, result_o and frame_cnt_o are unchanged, -> IDLE.
  - digit_i_valid in the same cycle as the timeout: the result wins, no timeout_o.
- digit_i_valid outside WAIT_RESULT (including during STREAM/GAP) is ignored.
- start coincident with a host write in IDLE: the write completes and streaming begins. Data is RAM-coherent because the first read issues the next cycle.
- rst mid-stream: immediate return to IDLE with reset outputs. No partial result or timeout pulse.
- busy rises the cycle after start is accepted and falls the cycle the FSM re-enters IDLE (same cycle as result_valid_o/timeout_o).

Decomposition:
- Package image_streamer_pkg: state enum (IDLE, STREAM, GAP, WAIT_RESULT), IMG_PIXELS, and pixel/digit width typedefs shared with the CNN top.
- One sub-module: image_frame_ram (single-clock simple dual-port, registered read). The FSM, counters and handshake logic stay in image_streamer.

Test Plan:
- Ramp load: RAM[a]=a[7:0] for a=0..783, start at edge N -> valid at N+2..N+785 back-to-back, values 0x00,0x01,...,0x0F (addr 783); busy high from N+1.
- Result handshake: after the stream, drive digit_i=7 with digit_i_valid 50 cycles later -> result_o=7, result_valid_o one pulse, frame_cnt_o=1, busy low.
- PIXEL_GAP=2: same ramp -> each valid pixel is followed by exactly 2 invalid cycles, 784 valids total, last valid at N+2+783*3.
- Timeout with TIMEOUT_CYCLES=100: no digit_i_valid -> timeout_o pulses once, result_o holds its previous value, frame_cnt_o unchanged, FSM back in IDLE and accepts a new start.
- Write during busy and address 800 in IDLE -> host_wr_err pulses for both, RAM readback unchanged. Spurious digit_i_valid during STREAM -> no result_valid_o.
- rst asserted at pixel 300 -> next cycle all outputs are reset values. A new start streams the full frame from pixel 0 with the RAM contents intact.
